mult_div_seq: RTL and testbench

//  Iterative signed MULT/DIV sequencer owning the HI/LO register pair of the multicycle MIPS core.
//  The main control FSM pulses start with the operation and operands, then waits for done.

---
 rtl/mult_div_seq.sv | 197 +++++++++++++++++++
 tb/tb_mult_div_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_seq.sv
// -----------------------------------------------------------------------------
// mult_div_seq
// Iterative signed MULT/DIV sequencer that owns the HI/LO register pair of the
// multicycle MIPS core. The control FSM pulses start with the operation and
// operands, waits for the one-cycle done pulse, then reads hi/lo.
//
// Optional feature macro: MULT_DIV_EARLY_OUT_EN
//   defined   : MULT leaves ITER as soon as the remaining multiplier is zero.
//   undefined : fixed latency, done is high in the cycle after edge E0+WIDTH+2.
//
// Ports
//   clk    in   1      clock, rising edge
//   reset  in   1      asynchronous, active-low reset
//   start  in   1      request, sampled only in IDLE
//   md_op  in   1      0 = MULT, 1 = DIV (sampled with start)
//   op_a   in   WIDTH  multiplicand / dividend (signed)
//   op_b   in   WIDTH  multiplier / divisor (signed)
//   busy   out  1      high in every non-IDLE state
//   done   out  1      one-cycle pulse, hi/lo already hold the new result
//   div0   out  1      combinational divide-by-zero flag: md_op & (op_b == 0)
//   hi     out  WIDTH  product upper half / remainder
//   lo     out  WIDTH  product lower half / quotient
// -----------------------------------------------------------------------------
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             md_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 op_q;          // latched md_op
    logic                 sign_a_q;
    logic                 sign_b_q;
    logic [2*WIDTH-1:0]   acc_q;         // MULT product accumulator
    logic [2*WIDTH-1:0]   mcand_q;       // MULT shifting multiplicand
    logic [WIDTH-1:0]     mplier_q;      // MULT shifting multiplier
    logic [WIDTH-1:0]     rem_q;         // DIV partial remainder
    logic [WIDTH-1:0]     quot_q;        // DIV dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]     divisor_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 busy_q;
    logic                 done_q;

    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]     mplier_d;
    logic [WIDTH:0]       rem_sh_s;
    logic                 div_ge_s;
    logic [WIDTH-1:0]     rem_d;
    logic [WIDTH-1:0]     quot_d;
    logic                 last_step_s;
    logic                 early_out_s;
    logic                 neg_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     quot_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;

    // Magnitude of a two's-complement value; |MIN| stays exact as an unsigned value.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        abs_val = v[WIDTH-1] ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    assign div0 = md_op & (op_b == {WIDTH{1'b0}});
    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // One shift-add / restoring-divide step plus the sign-correction values used in FIX.
    always_comb begin
        acc_d       = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_d    = {1'b0, mplier_q[WIDTH-1:1]};
        rem_sh_s    = {rem_q, quot_q[WIDTH-1]};
        div_ge_s    = (rem_sh_s >= {1'b0, divisor_q});
        // The shifted remainder is below 2*divisor, so the difference fits in WIDTH bits.
        rem_d       = div_ge_s ? (rem_sh_s[WIDTH-1:0] - divisor_q) : rem_sh_s[WIDTH-1:0];
        quot_d      = {quot_q[WIDTH-2:0], div_ge_s};
        last_step_s = (cnt_q == CNT_W'(WIDTH));
`ifdef MULT_DIV_EARLY_OUT_EN
        early_out_s = ~op_q & (mplier_d == {WIDTH{1'b0}});
`else
        early_out_s = 1'b0;
`endif
        neg_s       = sign_a_q ^ sign_b_q;
        prod_fix_s  = neg_s    ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
        quot_fix_s  = neg_s    ? ({WIDTH{1'b0}} - quot_q)    : quot_q;
        rem_fix_s   = sign_a_q ? ({WIDTH{1'b0}} - rem_q)     : rem_q;
    end

    // Sequencer FSM with all working registers and registered busy/done/hi/lo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            op_q      <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            acc_q     <= {(2*WIDTH){1'b0}};
            mcand_q   <= {(2*WIDTH){1'b0}};
            mplier_q  <= {WIDTH{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            quot_q    <= {WIDTH{1'b0}};
            divisor_q <= {WIDTH{1'b0}};
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !div0) begin
                        state_q   <= S_ITER;
                        busy_q    <= 1'b1;
                        cnt_q     <= {CNT_W{1'b0}};
                        op_q      <= md_op;
                        sign_a_q  <= op_a[WIDTH-1];
                        sign_b_q  <= op_b[WIDTH-1];
                        acc_q     <= {(2*WIDTH){1'b0}};
                        mcand_q   <= {{WIDTH{1'b0}}, abs_val(op_a)};
                        mplier_q  <= abs_val(op_b);
                        rem_q     <= {WIDTH{1'b0}};
                        quot_q    <= abs_val(op_a);
                        divisor_q <= abs_val(op_b);
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ITER: begin
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    // cnt == 0 is an alignment cycle; steps run for cnt = 1..WIDTH,
                    // which puts done WIDTH+2 edges after the accepting edge.
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        if (!op_q) begin
                            acc_q    <= acc_d;
                            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
                            mplier_q <= mplier_d;
                        end else begin
                            rem_q  <= rem_d;
                            quot_q <= quot_d;
                        end
                        if (last_step_s || early_out_s) begin
                            state_q <= S_FIX;
                        end else begin
                            state_q <= S_ITER;
                        end
                    end else begin
                        state_q <= S_ITER;
                    end
                end
                S_FIX: begin
                    // Sign-corrected result lands in hi/lo on the edge entering DONE.
                    if (!op_q) begin
                        hi_q <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix_s[WIDTH-1:0];
                    end else begin
                        hi_q <= rem_fix_s;
                        lo_q <= quot_fix_s;
                    end
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// -----------------------------------------------------------------------------
// tb_mult_div_seq
// Directed self-checking bench for mult_div_seq (WIDTH = 32). Expected values
// are hand-computed constants. Honours MULT_DIV_EARLY_OUT_EN for MULT latency.
// -----------------------------------------------------------------------------
module tb_mult_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        md_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int fails;

    mult_div_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edges from the accepting edge to the done cycle for a MULT with multiplier b.
    function automatic int mult_edges(input logic [31:0] b);
`ifdef MULT_DIV_EARLY_OUT_EN
        logic [31:0] m;
        int n;
        m = b[31] ? (32'd0 - b) : b;
        n = 1;
        m = m >> 1;
        while (m != 32'd0) begin
            n++;
            m = m >> 1;
        end
        return n + 2;
`else
        return (b === 32'hxxxx_xxxx) ? 0 : 34;
`endif
    endfunction

    // Issue one operation, wait for done (bounded), check latency, busy, result and single done.
    // inject > 0 pulses another start that many edges after acceptance.
    task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_edges, input int inject);
        int edges;
        int extra;
        logic got;
        logic busy_ok;
        @(posedge clk); #1;
        start = 1'b1; md_op = op; op_a = a; op_b = b;
        @(posedge clk); #1;                       // accepting edge E0
        start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D;
        edges = 0; got = 1'b0; busy_ok = 1'b1;
        while (edges < 200 && !got) begin
            @(posedge clk); #1;
            edges++;
            if (done) got = 1'b1;
            else if (!busy) busy_ok = 1'b0;
            if (edges == inject) begin
                start = 1'b1; md_op = 1'b0; op_a = 32'd3; op_b = 32'd5;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, " done seen"}, {63'd0, got}, 64'd1);
        check({tag, " latency"}, 64'(edges), 64'(exp_edges));
        check({tag, " busy held"}, {63'd0, busy_ok}, 64'd1);
        check({tag, " busy in done"}, {63'd0, busy}, 64'd1);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
        @(posedge clk); #1;
        check({tag, " busy after"}, {63'd0, busy}, 64'd0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check({tag, " no extra done"}, 64'(extra), 64'd0);
    endtask

    initial begin
        checks = 0; fails = 0;
        reset = 1'b0; start = 1'b0; md_op = 1'b0; op_a = 32'd0; op_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        reset = 1'b1;

        // MULT basics
        run_op("mult 7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB,
               mult_edges(32'hFFFF_FFFD), 0);
        run_op("mult -6x-7", 1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'd0, 32'd42,
               mult_edges(32'hFFFF_FFF9), 0);

        // DIV basics and boundaries
        run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 0);
        run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34, 0);
        run_op("div 100/7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 34, 0);
        run_op("div MIN/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34, 0);

        // DIV by zero: flag now, never accepted, hi/lo untouched (hi=0, lo=MIN from above)
        @(posedge clk); #1;
        start = 1'b1; md_op = 1'b0; op_a = 32'd5; op_b = 32'd0;
        #1;
        check("div0 on mult", {63'd0, div0}, 64'd0);
        md_op = 1'b1;
        #1;
        check("div0 flag", {63'd0, div0}, 64'd1);
        @(posedge clk); #1;
        check("div0 busy", {63'd0, busy}, 64'd0);
        start = 1'b0;
        begin
            int dz_done;
            logic dz_busy;
            dz_done = 0; dz_busy = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (done) dz_done++;
                if (busy) dz_busy = 1'b1;
            end
            check("div0 no done", 64'(dz_done), 64'd0);
            check("div0 never busy", {63'd0, dz_busy}, 64'd0);
        end
        check("div0 hi kept", {32'd0, hi}, 64'd0);
        check("div0 lo kept", {32'd0, lo}, {32'd0, 32'h8000_0000});

        // MIN x MIN with a start pulsed mid-operation
        run_op("mult MINxMIN", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,
               mult_edges(32'h8000_0000), 5);

        // Reset in the middle of ITER
        @(posedge clk); #1;
        start = 1'b1; md_op = 1'b0; op_a = 32'd100; op_b = 32'd200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid busy pre-reset", {63'd0, busy}, 64'd1);
        check("mid hi holds", {32'd0, hi}, {32'd0, 32'h4000_0000});
        reset = 1'b0;
        #1;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort hi", {32'd0, hi}, 64'd0);
        check("abort lo", {32'd0, lo}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_op("mult 3x4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, mult_edges(32'd4), 0);

        // Short multiplier (early-out when enabled)
        run_op("mult 5x1", 1'b0, 32'd5, 32'd1, 32'd0, 32'd5, mult_edges(32'd1), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
